adc_sample_arbiter: RTL and testbench

ADC_SAMPLE_ARBITER -- requirements
Module: adc_sample_arbiter

---
 rtl/adc_sample_arbiter.sv | 146 ++++++++++++++
 tb/tb_adc_sample_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_arbiter.sv
// -----------------------------------------------------------------------------
// adc_sample_arbiter
//
// Shares one multiplexed ADC core between four requesters. An idle arbiter
// picks the next requester round-robin, steers the ADC channel mux to that
// requester's channel, waits SETTLE_CYCLES clocks for the conversion to
// settle, then captures the result and returns it with a one-cycle pulse on
// that requester's rsp_valid bit.
//
// Ports
//   clk_clk        in   1   system clock, rising edge
//   reset_reset_n  in   1   asynchronous active-low reset
//   req            in   4   level request, bit i = requester i
//   req_chan       in  12   requested channel, requester i at [3i+2:3i]
//   rsp_valid      out  4   one-cycle pulse, bit i = rsp_data is for requester i
//   rsp_data       out 12   last captured sample, held until the next capture
//   busy           out  1   high while a grant is being serviced
//   adc_chan       out  3   channel select to the ADC core
//   adc_result     in  12   free-running ADC conversion result
// -----------------------------------------------------------------------------
module adc_sample_arbiter #(
  parameter int SETTLE_CYCLES = 2000   // legal range 1..65535
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [3:0]  req,
  input  logic [11:0] req_chan,
  output logic [3:0]  rsp_valid,
  output logic [11:0] rsp_data,
  output logic        busy,
  output logic [2:0]  adc_chan,
  input  logic [11:0] adc_result
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  localparam logic [15:0] CNT_LOAD = 16'(SETTLE_CYCLES - 1);

  state_e      state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic [1:0]  ptr_q,       ptr_d;
  logic [1:0]  win_q,       win_d;
  logic [2:0]  adc_chan_q,  adc_chan_d;
  logic [11:0] rsp_data_q,  rsp_data_d;
  logic [3:0]  rsp_valid_q, rsp_valid_d;
  logic        busy_q,      busy_d;

  logic [3:0]  eligible;
  logic        grant_found;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic [2:0]  chan_slice [4];

  for (genvar g = 0; g < 4; g++) begin : g_chan_slice
    assign chan_slice[g] = req_chan[3*g +: 3];
  end

  // A requester whose response pulse is on the bus this cycle sits out one
  // arbitration round, so a level request that is dropped late is not
  // mistaken for a fresh one.
  assign eligible = req & ~rsp_valid_q;

  // Round-robin search starting at ptr_q; first eligible requester wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = '0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    adc_chan_d  = adc_chan_q;   // channel is held in IDLE so the ADC keeps tracking it
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = '0;           // response is a single-cycle pulse
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          win_d      = grant_idx;
          adc_chan_d = chan_slice[grant_idx];
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          rsp_data_d         = adc_result;
          rsp_valid_d[win_q] = 1'b1;
          ptr_d              = win_q + 2'd1;
          busy_d             = 1'b0;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      adc_chan_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      adc_chan_q  <= adc_chan_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign adc_chan  = adc_chan_q;

endmodule

// File: tb/tb_adc_sample_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_arbiter
//
// Self-checking bench for adc_sample_arbiter with SETTLE_CYCLES = 4. Expected
// responses (requester, channel, captured data) are queued when a request is
// driven and popped when the matching rsp_valid pulse appears. Inputs are
// driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_adc_sample_arbiter;

  localparam int S = 4;

  logic        clk_clk;
  logic        reset_reset_n;
  logic [3:0]  req;
  logic [11:0] req_chan;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic        busy;
  logic [2:0]  adc_chan;
  logic [11:0] adc_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [2:0]  chan;
    logic [11:0] data;
  } exp_t;

  exp_t sb[$];

  adc_sample_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .req           (req),
    .req_chan      (req_chan),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .adc_chan      (adc_chan),
    .adc_result    (adc_result)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- utilities
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [2:0] c, input logic [11:0] d);
    exp_t e;
    e.idx  = idx;
    e.chan = c;
    e.data = d;
    sb.push_back(e);
  endtask

  // Steps edges until busy rises; n = edges taken, -1 if the budget expires.
  task automatic wait_grant(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (busy === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Steps edges until any rsp_valid bit is high; n = edges taken or -1.
  task automatic wait_rsp(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (rsp_valid !== 4'b0000) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = '0;
    v[idx[1:0]] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    reset_reset_n = 1'b0;
    req           = '0;
    req_chan      = '0;
    adc_result    = '0;
    sb.delete();
    repeat (2) tick();
    reset_reset_n = 1'b1;
    tick();
  endtask

  // -------------------------------------------------------------------- tests
  task automatic test_reset();
    reset_reset_n = 1'b0;
    req           = '0;
    req_chan      = '0;
    adc_result    = 12'hFFF;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
    end
    checks++;
    if (rsp_data !== 12'h000) begin
      errors++; $display("FAIL reset_rsp_data: got %h expected 000", rsp_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (adc_chan !== 3'd0) begin
      errors++; $display("FAIL reset_adc_chan: got %0d expected 0", adc_chan);
    end
    repeat (2) tick();
    reset_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int   n;
    exp_t e;
    do_reset();
    req_chan   = 12'd5;
    adc_result = 12'hABC;
    req        = 4'b0001;
    push(0, 3'd5, 12'hABC);
    wait_grant(8, n);
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL single_grant_edge: got %0d expected 1", n);
    end
    checks++;
    if (adc_chan !== 3'd5) begin
      errors++; $display("FAIL single_adc_chan: got %0d expected 5", adc_chan);
    end
    for (int i = 1; i < S; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_settle_%0d: got rsp_valid=%b busy=%b expected 0000/1",
                 i, rsp_valid, busy);
      end
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0001) begin
      errors++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_drop: got %b expected 0", busy);
    end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL single_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      checks++;
      if (rsp_data !== e.data) begin
        errors++; $display("FAIL single_rsp_data: got %h expected %h", rsp_data, e.data);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 12'hABC) begin
      errors++;
      $display("FAIL single_pulse_end: got rsp_valid=%b rsp_data=%h expected 0000/abc",
               rsp_valid, rsp_data);
    end
  endtask

  task automatic test_contention();
    int   n;
    exp_t e;
    do_reset();
    req_chan = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 5; k++) push(k % 4, 3'(k % 4), 12'h300 + 12'(k));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(8, n);
      checks++;
      if (n !== 1) begin
        errors++; $display("FAIL contention_grant_gap_%0d: got %0d expected 1", k, n);
      end
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL contention_sb_%0d: got empty queue expected entry", k);
      end else begin
        e = sb.pop_front();
        checks++;
        if (adc_chan !== e.chan) begin
          errors++; $display("FAIL contention_chan_%0d: got %0d expected %0d", k, adc_chan, e.chan);
        end
        adc_result = e.data;
        wait_rsp(8, n);
        checks++;
        if (n !== S) begin
          errors++; $display("FAIL contention_latency_%0d: got %0d expected %0d", k, n, S);
        end
        checks++;
        if (rsp_valid !== onehot(e.idx)) begin
          errors++;
          $display("FAIL contention_order_%0d: got %b expected %b", k, rsp_valid, onehot(e.idx));
        end
        checks++;
        if (rsp_data !== e.data) begin
          errors++; $display("FAIL contention_data_%0d: got %h expected %h", k, rsp_data, e.data);
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    int   n;
    exp_t e;
    do_reset();
    req_chan   = {3'd0, 3'd4, 3'd0, 3'd0};
    adc_result = 12'h0A2;
    req        = 4'b0100;
    wait_grant(8, n);
    wait_rsp(8, n);
    checks++;
    if (rsp_valid !== 4'b0100) begin
      errors++; $display("FAIL rotation_first: got %b expected 0100", rsp_valid);
    end
    req = 4'b0000;
    tick();
    // Pointer now sits at 3: requester 3 is idle, so the search wraps to 0.
    req_chan = {3'd0, 3'd7, 3'd0, 3'd1};
    push(0, 3'd1, 12'h0B0);
    push(2, 3'd7, 12'h0B2);
    req = 4'b0101;
    for (int r = 0; r < 2; r++) begin
      wait_grant(8, n);
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL rotation_sb_%0d: got empty queue expected entry", r);
      end else begin
        e = sb.pop_front();
        checks++;
        if (adc_chan !== e.chan) begin
          errors++; $display("FAIL rotation_chan_%0d: got %0d expected %0d", r, adc_chan, e.chan);
        end
        adc_result = e.data;
        wait_rsp(8, n);
        checks++;
        if (rsp_valid !== onehot(e.idx)) begin
          errors++;
          $display("FAIL rotation_order_%0d: got %b expected %b", r, rsp_valid, onehot(e.idx));
        end
        checks++;
        if (rsp_data !== e.data) begin
          errors++; $display("FAIL rotation_data_%0d: got %h expected %h", r, rsp_data, e.data);
        end
        req = req & ~onehot(e.idx);
      end
    end
    tick();
  endtask

  task automatic test_late_change();
    int   n;
    exp_t e;
    do_reset();
    req_chan   = 12'd5;
    adc_result = 12'h111;
    req        = 4'b0001;
    wait_grant(8, n);
    tick();
    req_chan   = 12'd1;
    adc_result = 12'h222;
    push(0, 3'd5, 12'h222);
    checks++;
    if (adc_chan !== 3'd5) begin
      errors++; $display("FAIL late_chan_settle: got %0d expected 5", adc_chan);
    end
    wait_rsp(8, n);
    checks++;
    if (n !== S - 1) begin
      errors++; $display("FAIL late_latency: got %0d expected %0d", n, S - 1);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== onehot(e.idx) || rsp_data !== e.data || adc_chan !== e.chan) begin
      errors++;
      $display("FAIL late_capture: got rsp_valid=%b data=%h chan=%0d expected %b/%h/%0d",
               rsp_valid, rsp_data, adc_chan, onehot(e.idx), e.data, e.chan);
    end
    req = 4'b0000;
    repeat (3) tick();
    checks++;
    if (adc_chan !== 3'd5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_idle_hold: got chan=%0d busy=%b expected 5/0", adc_chan, busy);
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    int   pulses;
    exp_t e;
    do_reset();
    req_chan   = {3'd0, 3'd0, 3'd6, 3'd0};
    adc_result = 12'h777;
    req        = 4'b0010;
    wait_grant(8, n);
    tick();
    tick();
    #2;
    reset_reset_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || adc_chan !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got rsp_valid=%b chan=%0d busy=%b expected 0000/0/0",
               rsp_valid, adc_chan, busy);
    end
    req = 4'b0000;
    tick();
    reset_reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 4'b0000) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", pulses);
    end
    // Pointer back at 0, so requester 0 wins over requester 1.
    req_chan   = {3'd0, 3'd0, 3'd6, 3'd2};
    adc_result = 12'h5A5;
    push(0, 3'd2, 12'h5A5);
    req = 4'b0011;
    wait_grant(8, n);
    checks++;
    if (n !== 1 || adc_chan !== 3'd2) begin
      errors++; $display("FAIL reset_mid_regrant: got edge=%0d chan=%0d expected 1/2", n, adc_chan);
    end
    wait_rsp(8, n);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== onehot(e.idx) || rsp_data !== e.data) begin
      errors++;
      $display("FAIL reset_mid_rsp: got %b/%h expected %b/%h",
               rsp_valid, rsp_data, onehot(e.idx), e.data);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    int   n;
    int   total;
    exp_t e;
    do_reset();
    req_chan   = {3'd0, 3'd0, 3'd3, 3'd0};
    adc_result = 12'h3C3;
    push(1, 3'd3, 12'h3C3);
    push(1, 3'd3, 12'h3C3);
    req = 4'b0010;
    wait_grant(8, n);
    wait_rsp(8, n);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== onehot(e.idx) || rsp_data !== e.data) begin
      errors++;
      $display("FAIL held_first: got %b/%h expected %b/%h", rsp_valid, rsp_data, onehot(e.idx), e.data);
    end
    // req stays high: the pulse cycle masks it, the following edge regrants.
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL held_masked: got busy=%b rsp_valid=%b expected 0/0000", busy, rsp_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || adc_chan !== 3'd3) begin
      errors++; $display("FAIL held_regrant: got busy=%b chan=%0d expected 1/3", busy, adc_chan);
    end
    wait_rsp(8, n);
    total = (n < 0) ? -1 : n + 2;
    // Second pulse S+2 edges after the first: five low cycles in between.
    checks++;
    if (total !== S + 2) begin
      errors++; $display("FAIL held_spacing: got %0d edges expected %0d", total, S + 2);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== onehot(e.idx) || rsp_data !== e.data) begin
      errors++;
      $display("FAIL held_second: got %b/%h expected %b/%h", rsp_valid, rsp_data, onehot(e.idx), e.data);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    reset_reset_n = 1'b0;
    req           = '0;
    req_chan      = '0;
    adc_result    = '0;
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_late_change();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
